// File: rtl/inv_round_shift_mix.sv
`default_nettype none
// ============================================================================
//  Module   : inv_round_shift_mix
//  Purpose  : AES inverse-round datapath stage. Computes
//             out = InvShiftRows(InvMixColumns(in_data ^ in_key)).
//             InvMixColumns can be bypassed for the last inverse round.
//             By default InvMixColumns runs one 32-bit column per cycle,
//             so the MIX state lasts four cycles.
//  Macro    : INV_ROUND_PARALLEL_MIX_EN - all four columns are mixed in
//             a single MIX cycle. Results are bit-identical.
//  Ports    : clk, rst_n        - clock, asynchronous active-low reset
//             in_valid/in_ready - input handshake (in_data, in_key,
//                                 in_skip_mix are sampled at the accept)
//             out_valid/out_ready - output handshake, out_data result
//  Revision : 1.0 - initial release
// ============================================================================
module inv_round_shift_mix (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    input  logic         in_skip_mix,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MIX  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]   r_state;
    logic [127:0] r_work;
    logic         r_skip;

    // GF(2^8) doubling, reduction polynomial 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Returns {09*b, 0b*b, 0d*b, 0e*b}.
    function automatic logic [31:0] gmul(input logic [7:0] b);
        logic [7:0] x2, x4, x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ b, x8 ^ x2 ^ b, x8 ^ x4 ^ b, x8 ^ x4 ^ x2};
    endfunction

    // InvMixColumns of one column; row 0 is the most significant byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [31:0] m0, m1, m2, m3;
        m0 = gmul(c[31:24]);
        m1 = gmul(c[23:16]);
        m2 = gmul(c[15:8]);
        m3 = gmul(c[7:0]);
        return {m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24],
                m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8],
                m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16],
                m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0]};
    endfunction

`ifdef INV_ROUND_PARALLEL_MIX_EN
    logic [127:0] w_mixed_all;

    for (genvar gi = 0; gi < 4; gi++) begin : g_par_mix
        assign w_mixed_all[127-32*gi -: 32] = inv_mix_col(r_work[127-32*gi -: 32]);
    end
`else
    logic [1:0]  r_col;
    logic [31:0] w_cur_col;
    logic [31:0] w_mixed_col;

    always_comb begin
        w_cur_col = r_work[127:96];
        case (r_col)
            2'd0:    w_cur_col = r_work[127:96];
            2'd1:    w_cur_col = r_work[95:64];
            2'd2:    w_cur_col = r_work[63:32];
            default: w_cur_col = r_work[31:0];
        endcase
    end

    assign w_mixed_col = inv_mix_col(w_cur_col);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_skip  <= 1'b0;
`ifndef INV_ROUND_PARALLEL_MIX_EN
            r_col   <= 2'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_data ^ in_key;
                        r_skip  <= in_skip_mix;
`ifndef INV_ROUND_PARALLEL_MIX_EN
                        r_col   <= 2'd0;
`endif
                        r_state <= in_skip_mix ? S_OUT : S_MIX;
                    end
                end
                S_MIX: begin
                    // MIX is only entered with skip clear; the guard keeps
                    // the work register untouched should that ever change.
`ifdef INV_ROUND_PARALLEL_MIX_EN
                    if (!r_skip) begin
                        r_work <= w_mixed_all;
                    end
                    r_state <= S_OUT;
`else
                    if (!r_skip) begin
                        case (r_col)
                            2'd0:    r_work[127:96] <= w_mixed_col;
                            2'd1:    r_work[95:64]  <= w_mixed_col;
                            2'd2:    r_work[63:32]  <= w_mixed_col;
                            default: r_work[31:0]   <= w_mixed_col;
                        endcase
                    end
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'd3) begin
                        r_state <= S_OUT;
                    end
`endif
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);

    // InvShiftRows: output column c, row r takes input column (c - r) mod 4.
    for (genvar gc = 0; gc < 4; gc++) begin : g_isr_col
        for (genvar gr = 0; gr < 4; gr++) begin : g_isr_row
            assign out_data[127-32*gc-8*gr -: 8] =
                r_work[127-32*((gc-gr+4)%4)-8*gr -: 8];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inv_round_shift_mix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inv_round_shift_mix
//  Purpose  : Directed self-checking bench for inv_round_shift_mix.
//             Honours INV_ROUND_PARALLEL_MIX_EN for the mixing latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inv_round_shift_mix;

`ifdef INV_ROUND_PARALLEL_MIX_EN
    localparam int C_MIX_LAT = 2;
`else
    localparam int C_MIX_LAT = 5;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         in_skip_mix = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    int checks = 0;
    int errors = 0;

    inv_round_shift_mix u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_key      (in_key),
        .in_skip_mix (in_skip_mix),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one state; returns #1 after the accept edge with inputs scrambled.
    task automatic accept(input string tag, input logic [127:0] d, input logic [127:0] k,
                          input logic skip);
        @(negedge clk);
        in_data     = d;
        in_key      = k;
        in_skip_mix = skip;
        in_valid    = 1'b1;
        check({tag, "_in_ready"}, 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_data     = ~d;
        in_key      = d;
        in_skip_mix = ~skip;
    endtask

    task automatic run_txn(input string tag, input logic [127:0] d, input logic [127:0] k,
                           input logic skip, input int exp_lat, input logic [127:0] exp_out);
        int lat;
        accept(tag, d, k, skip);
        lat = 1;
        if (!skip) check({tag, "_busy"}, 128'(in_ready), 128'(1'b0));
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_data"}, out_data, exp_out);
    endtask

    task automatic finish_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ovalid_low"}, 128'(out_valid), 128'(1'b0));
        check({tag, "_iready_high"}, 128'(in_ready), 128'(1'b1));
    endtask

    localparam logic [127:0] C_MIX_IN  = {4{32'h8e4da1bc}};
    localparam logic [127:0] C_MIX_OUT = {4{32'hdb135345}};

    initial begin
        logic [127:0] held;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_out_data", out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mixing path
        run_txn("mix", C_MIX_IN, 128'h0, 1'b0, C_MIX_LAT, C_MIX_OUT);
        finish_out("mix");

        // Same result through a non-zero round key
        run_txn("mix_key", {4{32'h71b25e43}}, {4{32'hffffffff}}, 1'b0, C_MIX_LAT, C_MIX_OUT);
        finish_out("mix_key");

        // Four distinct columns: exercises every column slot and the row rotation
        run_txn("mix_cols",
                {32'h8e4da1bc, 32'h9fdc589d, 32'hd5d5d7d6, 32'h4d7ebdf8}, 128'h0, 1'b0,
                C_MIX_LAT,
                {32'hdb26d45c, 32'hf21331d5, 32'hd40a534c, 32'h2dd42245});
        finish_out("mix_cols");

        // Shift-only path
        run_txn("shift", 128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0, 1'b1, 1,
                128'h000d0a07_04010e0b_0805020f_0c090603);
        finish_out("shift");

        // AddRoundKey cancels to zero
        run_txn("ark_zero", 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
                128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, 1'b0, C_MIX_LAT, 128'h0);
        finish_out("ark_zero");

        // Fixed-point columns: only the row rotation is visible
        run_txn("fixpt", 128'h01010101_c6c6c6c6_01010101_c6c6c6c6, 128'h0, 1'b0, C_MIX_LAT,
                128'h01c601c6_c601c601_01c601c6_c601c601);
        finish_out("fixpt");

        // Backpressure: result held, no accept while in OUT
        run_txn("bp", C_MIX_IN, 128'h0, 1'b0, C_MIX_LAT, C_MIX_OUT);
        held = out_data;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_data  = {4{$urandom()}};
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check("bp_data_hold", out_data, held);
            check("bp_in_ready", 128'(in_ready), 128'(1'b0));
            check("bp_out_valid", 128'(out_valid), 128'(1'b1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        finish_out("bp");
        check("bp_out_data_kept", out_data, C_MIX_OUT);

        // Asynchronous reset in the second MIX cycle
        accept("rstmix", {4{32'h12345678}}, 128'h0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rstmix_out_valid", 128'(out_valid), 128'(1'b0));
        check("rstmix_out_data", out_data, 128'h0);
        check("rstmix_in_ready", 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rstmix_ready_after", 128'(in_ready), 128'(1'b1));
        run_txn("post_rst", C_MIX_IN, 128'h0, 1'b0, C_MIX_LAT, C_MIX_OUT);
        finish_out("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inv_round_shift_mix.md
Name: inv_round_shift_mix

Overview:
- Multi-cycle inverse-cipher datapath stage for the AES decryption path.
- Computes out = InvShiftRows(InvMixColumns(in_data ^ in_key)), with InvMixColumns optionally skipped for the final inverse round.
- Uses column-serial InvMixColumns: one 32-bit column per cycle, for area.
- Sits between the round-key source and the external InvSubBytes stage; valid/ready handshake on both sides.

Parameters:
- None. The state is fixed at 128 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input state and key valid
- in_ready  out  1  block can accept a state
- in_data  in  128  AES state
- in_key  in  128  round key
- in_skip_mix  in  1  bypass InvMixColumns (last inverse round)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_data  out  128  result state

Behaviour:
- State layout:
  - Column c occupies bits [127-32c -: 32].
  - Row r of a column is byte [31-8r -: 8] of that column.
  - Column 0 is in_data[127:96]; its row 0 is in_data[127:120].
- InvShiftRows: output column c, row r = input column (c - r) mod 4, row r. Row r is rotated right by r.
- InvMixColumns, per column, in GF(2^8) with polynomial 0x11B:
  - s0' = 0e·s0 ^ 0b·s1 ^ 0d·s2 ^ 09·s3
  - The other rows use the same coefficients rotated.
- Registers:
  - work[127:0]
  - col[1:0]
  - skip flag
  - FSM state
- FSM states and transitions:
  - IDLE:
    - in_ready = 1.
    - On in_valid: work <= in_data ^ in_key, skip flag <= in_skip_mix, col <= 0.
    - Next state is OUT if in_skip_mix, else MIX.
  - MIX:
    - in_ready = 0.
    - Each cycle, column col of work is replaced by its InvMixColumns result, and col increments.
    - After col = 3 is processed, go to OUT. Four cycles in MIX.
  - OUT:
    - out_valid = 1; out_data = InvShiftRows(work), driven combinationally from the register.
    - On out_ready, go to IDLE.
- Latency from handshake cycle N: out_valid rises at N+5 with mixing, N+1 with skip.
- No new input is accepted while in OUT. in_ready returns high only in the cycle after the out handshake. There is no back-to-back accept.
- Backpressure: out_data and out_valid stay stable while out_ready is low, for unbounded time.
- in_data, in_key and in_skip_mix are sampled only at the accept edge; later changes have no effect.
- Reset, asynchronous, at any time including mid-MIX:
  - FSM goes to IDLE; work, col and skip are cleared.
  - out_valid = 0; out_data = 0; in_ready = 1 (IDLE).
  - Any in-flight state is discarded.
- out_valid is never asserted in IDLE or MIX.

Optional Feature:
- Macro: INV_ROUND_PARALLEL_MIX_EN.
- Defined:
  - Four InvMixColumns instances process all columns in one cycle.
  - MIX lasts exactly one cycle, then goes to OUT; col is unused.
  - Latency with mixing becomes N+2; skip latency stays N+1.
  - Results are bit-identical to the serial build.
- Undefined: the column-serial behaviour above.

Test Plan:
- Mixing path:
  - Stimulus: in_data = 8e4da1bc repeated in all four columns, in_key = 0, skip = 0.
  - Response: out_valid exactly 5 cycles after accept; out_data = db135345 in all four columns.
- Shift-only path:
  - Stimulus: skip = 1, in_key = 0, in_data = 00010203_04050607_08090a0b_0c0d0e0f.
  - Response: out_valid 1 cycle after accept; out_data = 000d0a07_04010e0b_0805020f_0c090603.
- AddRoundKey:
  - Stimulus: in_data = in_key = 2b7e1516_28aed2a6_abf71588_09cf4f3c, skip = 0.
  - Response: out_data = 0.
  - Stimulus: in_data = 01010101 and c6c6c6c6 columns alternating, key = 0.
  - Response: out_data = InvShiftRows of the input (fixed-point columns).
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles in OUT while changing in_data and asserting in_valid.
  - Response: out_data unchanged, in_ready = 0, no second accept.
  - Stimulus: then release out_ready.
  - Response: one out handshake; in_ready = 1 on the following cycle.
- Reset mid-operation:
  - Stimulus: pull rst_n low during MIX cycle 2, asynchronously and not clock-aligned.
  - Response: out_valid = 0 and out_data = 0 immediately; in_ready = 1 after release; the next transaction completes correctly.
- Build with INV_ROUND_PARALLEL_MIX_EN:
  - Stimulus: repeat the mixing-path scenario.
  - Response: out_valid 2 cycles after accept; same out_data.
